// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Z80 / LCD fetch arbiter for the shared physical memory bus.
// The CPU always wins the bus; a starved LCD read freezes the Z80 between cycles.
module mem_arbiter #(
  parameter int AW      = 22,
  parameter int LCD_ACC = 3,
  parameter int STARVE  = 16
) (
  input  logic          mck,
  input  logic          rin_n,
  input  logic [AW-1:0] cpu_ma,
  input  logic          cpu_mrq_n,
  input  logic          cpu_rd_n,
  input  logic          lcd_req,
  input  logic [AW-1:0] lcd_addr,
  input  logic [7:0]    mem_di,
  output logic [AW-1:0] ma,
  output logic          roe_n,
  output logic          wrb_n,
  output logic          lcd_ack,
  output logic [7:0]    lcd_data,
  output logic          cpu_hold,
  output logic [7:0]    steal_cnt
);

  typedef enum logic [1:0] {IDLE, CPU, LCD} state_t;

  localparam logic [1:0] ACC_INIT   = 2'(LCD_ACC - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE);

  state_t        state;
  logic [1:0]    acc_cnt;
  logic [7:0]    wait_cnt;
  logic [AW-1:0] lcd_addr_q;
  logic [7:0]    data_q;
  logic          acc_done;
  logic          force_hold;

  // The final access cycle is the ack cycle, so read data is forwarded straight from the bus.
  assign acc_done = (state == LCD) && (acc_cnt == 2'd0);
  assign lcd_ack  = acc_done;
  assign lcd_data = acc_done ? mem_di : data_q;

  assign force_hold = (state != LCD) && !cpu_hold && lcd_req && cpu_mrq_n &&
                      (wait_cnt == STARVE_MAX);

  always_comb begin
    ma    = cpu_ma;
    roe_n = !(!cpu_mrq_n && !cpu_rd_n);
    wrb_n = !(!cpu_mrq_n && cpu_rd_n);
    if (state == LCD) begin
      ma    = lcd_addr_q;
      roe_n = 1'b0;
      wrb_n = 1'b1;
    end
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state      <= IDLE;
      acc_cnt    <= 2'd0;
      wait_cnt   <= 8'd0;
      lcd_addr_q <= '0;
      data_q     <= 8'h00;
      cpu_hold   <= 1'b0;
      steal_cnt  <= 8'd0;
    end else begin
      case (state)
        IDLE, CPU: begin
          if (!cpu_mrq_n) begin
            state <= CPU;
          end else if (lcd_req) begin
            state      <= LCD;
            lcd_addr_q <= lcd_addr;
            acc_cnt    <= ACC_INIT;
          end else begin
            state <= IDLE;
          end
        end
        LCD: begin
          if (acc_cnt == 2'd0) begin
            data_q <= mem_di;
            state  <= cpu_mrq_n ? IDLE : CPU;
          end else begin
            acc_cnt <= acc_cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // A dropped request counts as abandoned, so its wait history is discarded.
      if (acc_done || !lcd_req) begin
        wait_cnt <= 8'd0;
      end else if (state != LCD && wait_cnt != STARVE_MAX) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (acc_done) begin
        cpu_hold <= 1'b0;
      end else if (force_hold) begin
        cpu_hold <= 1'b1;
        if (steal_cnt != 8'hFF) steal_cnt <= steal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        mck = 1'b0;
  logic        rin_n;
  logic [21:0] cpu_ma;
  logic        cpu_mrq_n;
  logic        cpu_rd_n;
  logic        lcd_req;
  logic [21:0] lcd_addr;
  logic [7:0]  mem_di;
  logic [21:0] ma;
  logic        roe_n;
  logic        wrb_n;
  logic        lcd_ack;
  logic [7:0]  lcd_data;
  logic        cpu_hold;
  logic [7:0]  steal_cnt;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(22), .LCD_ACC(3), .STARVE(16)) dut (
    .mck(mck), .rin_n(rin_n), .cpu_ma(cpu_ma), .cpu_mrq_n(cpu_mrq_n), .cpu_rd_n(cpu_rd_n),
    .lcd_req(lcd_req), .lcd_addr(lcd_addr), .mem_di(mem_di), .ma(ma), .roe_n(roe_n),
    .wrb_n(wrb_n), .lcd_ack(lcd_ack), .lcd_data(lcd_data), .cpu_hold(cpu_hold),
    .steal_cnt(steal_cnt)
  );

  always #5 mck = ~mck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mck);
    #1;
  endtask

  initial begin
    rin_n = 1'b0; cpu_ma = 22'h123456; cpu_mrq_n = 1'b1; cpu_rd_n = 1'b1;
    lcd_req = 1'b0; lcd_addr = '0; mem_di = 8'h00;
    #3;
    chk("rst_ma", ma, 22'h123456);
    chk("rst_roe", roe_n, 1'b1);
    chk("rst_wrb", wrb_n, 1'b1);
    chk("rst_ack", lcd_ack, 1'b0);
    chk("rst_data", lcd_data, 8'h00);
    chk("rst_hold", cpu_hold, 1'b0);
    chk("rst_steal", steal_cnt, 8'd0);
    tick();
    rin_n = 1'b1;
    tick();

    // Idle CPU: plain LCD read, ack in the third access cycle.
    lcd_req = 1'b1; lcd_addr = 22'h0A1234; mem_di = 8'h5A;
    #1;
    chk("t1_idle_ma", ma, 22'h123456);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t1_ma_c%0d", i), ma, 22'h0A1234);
      chk($sformatf("t1_roe_c%0d", i), roe_n, 1'b0);
      chk($sformatf("t1_wrb_c%0d", i), wrb_n, 1'b1);
      chk($sformatf("t1_ack_c%0d", i), lcd_ack, (i == 3));
      chk($sformatf("t1_hold_c%0d", i), cpu_hold, 1'b0);
    end
    chk("t1_data", lcd_data, 8'h5A);
    lcd_req = 1'b0;
    tick();
    chk("t1_ack_after", lcd_ack, 1'b0);
    chk("t1_ma_after", ma, 22'h123456);
    chk("t1_roe_after", roe_n, 1'b1);
    chk("t1_data_held", lcd_data, 8'h5A);

    // CPU priority: simultaneous CPU read and LCD request.
    cpu_mrq_n = 1'b0; cpu_rd_n = 1'b0; cpu_ma = 22'h200010;
    lcd_req = 1'b1; lcd_addr = 22'h155555; mem_di = 8'h3C;
    #1;
    chk("t2_ma0", ma, 22'h200010);
    chk("t2_roe0", roe_n, 1'b0);
    chk("t2_wrb0", wrb_n, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t2_ma_c%0d", i), ma, 22'h200010);
      chk($sformatf("t2_roe_c%0d", i), roe_n, 1'b0);
      chk($sformatf("t2_ack_c%0d", i), lcd_ack, 1'b0);
    end
    cpu_mrq_n = 1'b1; cpu_rd_n = 1'b1;
    #1;
    chk("t2_release_roe", roe_n, 1'b1);
    tick();
    chk("t2_grant_ma", ma, 22'h155555);
    chk("t2_grant_roe", roe_n, 1'b0);
    tick();
    tick();
    chk("t2_ack", lcd_ack, 1'b1);
    chk("t2_data", lcd_data, 8'h3C);
    chk("t2_hold", cpu_hold, 1'b0);
    lcd_req = 1'b0;
    tick();
    chk("t2_ack_after", lcd_ack, 1'b0);

    // Starvation: 20 CPU cycles with the LCD waiting, then a forced hold.
    cpu_mrq_n = 1'b0; cpu_rd_n = 1'b0; cpu_ma = 22'h000100;
    lcd_req = 1'b1; lcd_addr = 22'h2ABCDE; mem_di = 8'hC3;
    #1;
    for (int i = 1; i <= 19; i++) begin
      tick();
      chk($sformatf("t3_hold_c%0d", i), cpu_hold, 1'b0);
      chk($sformatf("t3_ma_c%0d", i), ma, 22'h000100);
    end
    tick();
    cpu_mrq_n = 1'b1; cpu_rd_n = 1'b1;
    #1;
    chk("t3_hold_at_rise", cpu_hold, 1'b0);
    chk("t3_steal_at_rise", steal_cnt, 8'd0);
    tick();
    chk("t3_hold_set", cpu_hold, 1'b1);
    chk("t3_steal_1", steal_cnt, 8'd1);
    chk("t3_ma_lcd", ma, 22'h2ABCDE);
    chk("t3_ack_c1", lcd_ack, 1'b0);
    tick();
    chk("t3_hold_c2", cpu_hold, 1'b1);
    chk("t3_ack_c2", lcd_ack, 1'b0);
    tick();
    chk("t3_ack", lcd_ack, 1'b1);
    chk("t3_data", lcd_data, 8'hC3);
    chk("t3_hold_in_ack", cpu_hold, 1'b1);
    lcd_req = 1'b0;
    tick();
    chk("t3_hold_clear", cpu_hold, 1'b0);
    chk("t3_steal_keep", steal_cnt, 8'd1);
    chk("t3_ack_after", lcd_ack, 1'b0);

    // CPU write arriving in the second LCD cycle waits for the ack.
    cpu_mrq_n = 1'b1; cpu_rd_n = 1'b1; cpu_ma = 22'h0F0F0F;
    lcd_req = 1'b1; lcd_addr = 22'h3FFFFF; mem_di = 8'h81;
    tick();
    chk("t4_ma_c1", ma, 22'h3FFFFF);
    tick();
    cpu_mrq_n = 1'b0;
    #1;
    chk("t4_ma_c2", ma, 22'h3FFFFF);
    chk("t4_wrb_c2", wrb_n, 1'b1);
    chk("t4_roe_c2", roe_n, 1'b0);
    tick();
    chk("t4_ack", lcd_ack, 1'b1);
    chk("t4_data", lcd_data, 8'h81);
    chk("t4_ma_c3", ma, 22'h3FFFFF);
    chk("t4_wrb_c3", wrb_n, 1'b1);
    lcd_req = 1'b0;
    tick();
    chk("t4_cpu_ma", ma, 22'h0F0F0F);
    chk("t4_cpu_wrb", wrb_n, 1'b0);
    chk("t4_cpu_roe", roe_n, 1'b1);
    chk("t4_ack_after", lcd_ack, 1'b0);
    cpu_mrq_n = 1'b1;
    tick();

    // Back-to-back: request held high across the ack.
    lcd_req = 1'b1; lcd_addr = 22'h111111; mem_di = 8'h11;
    tick();
    chk("t5_a_ma", ma, 22'h111111);
    tick();
    tick();
    chk("t5_a_ack", lcd_ack, 1'b1);
    chk("t5_a_data", lcd_data, 8'h11);
    tick();
    chk("t5_gap_ack", lcd_ack, 1'b0);
    chk("t5_gap_roe", roe_n, 1'b1);
    lcd_addr = 22'h222222; mem_di = 8'h22;
    tick();
    chk("t5_b_ma", ma, 22'h222222);
    chk("t5_b_ack_c1", lcd_ack, 1'b0);
    tick();
    chk("t5_b_ack_c2", lcd_ack, 1'b0);
    tick();
    chk("t5_b_ack", lcd_ack, 1'b1);
    chk("t5_b_data", lcd_data, 8'h22);
    lcd_req = 1'b0;
    tick();
    chk("t5_b_after", lcd_ack, 1'b0);

    // Asynchronous reset in the second LCD cycle aborts the access.
    lcd_req = 1'b1; lcd_addr = 22'h0A1234; mem_di = 8'h77;
    tick();
    tick();
    chk("t6_in_lcd", ma, 22'h0A1234);
    rin_n = 1'b0;
    #1;
    chk("t6_ma", ma, 22'h0F0F0F);
    chk("t6_roe", roe_n, 1'b1);
    chk("t6_wrb", wrb_n, 1'b1);
    chk("t6_ack", lcd_ack, 1'b0);
    chk("t6_data", lcd_data, 8'h00);
    chk("t6_hold", cpu_hold, 1'b0);
    chk("t6_steal", steal_cnt, 8'd0);
    lcd_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("t6_noack_c%0d", i), lcd_ack, 1'b0);
    end
    rin_n = 1'b1;
    tick();
    chk("t6_post_ack", lcd_ack, 1'b0);
    chk("t6_post_roe", roe_n, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the physical memory bus (22-bit ma, roe_n, wrb_n) between the Z80 and the LCD fetch engine. The LCD fetch engine reads from the pb0–pb3/sbr regions.
- CPU requests always win. LCD reads are slotted into CPU idle windows.
- A starved LCD request forces cpu_hold, which gates pm1 and freezes the Z80 clock until the LCD read completes.
- Sits between the address-translation logic (segment registers) and the memory chip-select/OE/WE outputs.

Parameters:
- AW, 22, physical address width.
- LCD_ACC, 3, mck cycles per LCD read access; legal range 1–3.
- STARVE, 16, mck cycles an LCD request may wait before cpu_hold is forced; legal range 2–255.

Ports:
- mck  in  1  master clock, all state on rising edge.
- rin_n  in  1  asynchronous active-low reset.
- cpu_ma  in  AW  translated CPU physical address.
- cpu_mrq_n  in  1  Z80 MREQ, active low.
- cpu_rd_n  in  1  Z80 RD, active low.
- lcd_req  in  1  LCD read request, level; held until lcd_ack.
- lcd_addr  in  AW  LCD read address; stable while lcd_req is high.
- mem_di  in  8  memory read data.
- ma  out  AW  physical memory address.
- roe_n  out  1  memory output enable, active low.
- wrb_n  out  1  memory write enable, active low.
- lcd_ack  out  1  one-cycle pulse; lcd_data is valid in the same cycle.
- lcd_data  out  8  captured LCD read byte.
- cpu_hold  out  1  high = pm1 gated, Z80 frozen.
- steal_cnt  out  8  saturating count of forced holds.

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE; wait_cnt, acc_cnt, steal_cnt = 0.
  - lcd_ack = 0, lcd_data = 0x00, cpu_hold = 0.
  - ma, roe_n and wrb_n follow the CPU passthrough equations below.
- Reset mid-LCD access aborts the access with no ack; the requester must re-request.
- States: IDLE, CPU, LCD.
- Output mux, combinational from state:
  - IDLE/CPU: ma = cpu_ma; roe_n = !(!cpu_mrq_n & !cpu_rd_n); wrb_n = !(!cpu_mrq_n & cpu_rd_n).
  - LCD: ma = latched lcd_addr; roe_n = 0; wrb_n = 1.
- IDLE transitions:
  - cpu_mrq_n = 0 -> CPU (priority).
  - Else, if lcd_req = 1 and lcd_ack = 0 -> LCD; latch lcd_addr; acc_cnt = LCD_ACC-1.
- CPU transitions:
  - Stay while cpu_mrq_n = 0.
  - On cpu_mrq_n = 1: go to LCD if lcd_req (same latch rules as IDLE), else IDLE.
- LCD transitions:
  - Decrement acc_cnt each cycle.
  - On acc_cnt = 0 (cycle k): capture mem_di into lcd_data, pulse lcd_ack for one cycle, clear wait_cnt and cpu_hold.
  - Next state: CPU if cpu_mrq_n = 0, else IDLE.
- Latency: from LCD entry to lcd_ack is LCD_ACC cycles.
- CPU request arriving during LCD:
  - The CPU request is not serviced until the LCD read finishes; the bus is not preempted.
  - The state moves to CPU right after ack.
  - Max CPU delay is LCD_ACC mck, which is below the Z80 T2 sampling margin at mck/3.
- Request handshake:
  - lcd_req is ignored in the cycle lcd_ack = 1, so the same request is never serviced twice.
  - A new request is accepted from the following cycle.
- Starvation counter (wait_cnt):
  - Increments each cycle with lcd_req = 1 and state != LCD; saturates at STARVE.
  - When wait_cnt = STARVE and cpu_mrq_n = 1, cpu_hold is registered to 1 and steal_cnt increments (saturates at 255).
  - cpu_hold is never asserted while cpu_mrq_n = 0. This avoids freezing the Z80 mid-cycle.
  - With hold set, the Z80 is frozen, cpu_mrq_n stays high, and the state enters LCD.
  - cpu_hold drops on the cycle after lcd_ack.
- Simultaneous events:
  - cpu_mrq_n falling and lcd_req rising in IDLE in the same cycle -> CPU wins.
  - lcd_req dropped before ack: the request is treated as abandoned. wait_cnt clears. An LCD access already in progress completes and acks (ack is ignored by the requester).

Test Plan:
- Reset then idle CPU: cpu_mrq_n=1, lcd_req pulse with lcd_addr=0x0A1234, mem_di=0x5A -> ma=0x0A1234 with roe_n=0 for 3 cycles; lcd_ack on cycle 3 with lcd_data=0x5A; cpu_hold stays 0.
- CPU priority: cpu_mrq_n=0, cpu_rd_n=0, cpu_ma=0x200010 and lcd_req asserted together -> ma=0x200010, roe_n=0, no ack while mrq is low; LCD granted on the first cycle mrq is high.
- Starvation: lcd_req held, CPU mrq low 20 cycles then high -> wait_cnt saturates at 16; cpu_hold=1 the cycle after mrq rises; steal_cnt=1; ack follows 3 cycles later; cpu_hold clears the next cycle.
- CPU during LCD: mrq falls in the 2nd LCD cycle -> ma stays lcd_addr until ack; state goes to CPU on the next cycle; wrb_n follows cpu_rd_n=1 as 0 (write).
- Back-to-back: lcd_req held high across ack -> no duplicate ack in the ack cycle; a second access begins the following cycle.
- Async reset mid-LCD (cycle 2) -> all outputs return to reset values immediately; no lcd_ack; steal_cnt=0.
